tx_iq_sample_buffer: RTL and testbench
======================================

// Module: tx_iq_sample_buffer
// PURPOSE
//   Elastic FIFO for complex baseband samples, downstream of the transmitter.
//   Captures signed real/imag sample pairs from the transmitter's output stage.
//   Presents them to the DAC/link interface over a valid/ready stream.
//   Counts occupancy and flags dropped samples, so bursty consumers do not lose data silently.
// PARAMETERS
//   DATA_W  16  width of each signed real/imag component
//   DEPTH   16  number of sample pairs stored; must be a power of two, >= 4
//   ADDR_W   4  log2(DEPTH)
// PORTS
//   clk        in   1         single clock; all state updates on rising edge
//   reset      in   1         asynchronous, active-low reset
//   in_valid   in   1         producer has a sample pair on real_in/imag_in
//   real_in    in   DATA_W    signed real component
//   imag_in    in   DATA_W    signed imaginary component
//   in_ready   out  1         buffer can accept a pair this cycle (= !full)
//   out_valid  out  1         real_out/imag_out hold the oldest stored pair (= !empty)
//   real_out   out  DATA_W    signed real component at head of FIFO
//   imag_out   out  DATA_W    signed imaginary component at head of FIFO
//   out_ready  in   1         consumer takes the head pair this cycle
//   level      out  ADDR_W+1  number of stored pairs, 0..DEPTH
//   overflow   out  1         sticky: a pair was offered while full and dropped
//   clr_ovf    in   1         synchronous clear of overflow (and peak_mag if enabled)
// BEHAVIOUR
//   - Reset (reset=0, async): wr_ptr=rd_ptr=0, level=0, out_valid=0, in_ready=1, overflow=0.
//     real_out/imag_out are undefined while out_valid=0; bench must not check them.
//   - Reset mid-operation discards all stored samples immediately; no partial pair survives.
//   - Write: in_valid & in_ready at edge -> pair stored at wr_ptr, wr_ptr++ (mod DEPTH).
//   - Read: out_valid & out_ready at edge -> rd_ptr++ (mod DEPTH), head advances.
//   - Output is first-word-fall-through: head pair is driven combinationally from storage.
//     A pair written at edge N gives out_valid=1 with that pair after edge N.
//     Minimum latency is 1 cycle; no added latency when non-empty.
//   - Pointers are ADDR_W+1 bits; the MSB distinguishes full from empty.
//     full  = ptrs equal except MSB
//     empty = ptrs fully equal
//     Wrap past DEPTH-1 to 0 is seamless.
//   - level: registered, updated the same edge as pointers.
//     +1 on write only, -1 on read only, unchanged on simultaneous write+read.
//   - Simultaneous write+read when full: in_ready=0, so the write is refused; the read proceeds.
//     The next cycle has level=DEPTH-1 and in_ready=1.
//   - Simultaneous write+read when empty: the write is accepted and no read occurs (out_valid=0).
//     The next cycle has level=1.
//   - Overflow: in_valid=1 & in_ready=0 at an edge -> the pair is dropped and overflow<=1.
//     It stays set until clr_ovf=1 at an edge. If clr_ovf and a new drop coincide, set wins.
//   - Data is passed bit-exact; no scaling, rounding or sign change.
// CONFIGURATION
//   IQ_PEAK_EN defined:
//     - adds output port peak_mag [DATA_W-1:0], unsigned, reset 0.
//     - On each accepted write: peak_mag <= max(peak_mag, |real_in|, |imag_in|).
//     - |-2^(DATA_W-1)| saturates to 2^(DATA_W-1)-1.
//     - clr_ovf=1 also clears peak_mag to 0. If clear and write coincide, peak_mag takes that write's magnitude.
//   IQ_PEAK_EN undefined: no peak_mag port and no peak logic; all other behaviour is identical.
// TESTING
//   1. Reset, then write 3 pairs (100,-100),(200,-200),(300,-300) with out_ready=0
//      -> level=3, out_valid=1, head=(100,-100), overflow=0.
//   2. Write 16 pairs with out_ready=0, then offer a 17th (7,7)
//      -> in_ready=0 after the 16th, level=16, overflow=1, (7,7) never appears at the output.
//   3. At full, in_valid=1 & out_ready=1 for one cycle
//      -> one pair read, write refused, level=15. The next cycle accepts a write: level=16.
//   4. Stream 40 pairs, value k=0..39, with in_valid=out_ready=1 continuously
//      -> output order is 0..39 with no gaps after the first cycle. level stays at 1 and pointers wrap twice.
//   5. Assert reset=0 mid-stream at level=5 -> level=0, out_valid=0, and overflow=0 immediately, asynchronously.
//      After release, the first new write is the first pair read.
//   6. With IQ_PEAK_EN, write (-32768,5) then (1000,-2000)
//      -> peak_mag=32767. Pulse clr_ovf -> peak_mag=0 and overflow=0.

Source files
------------

// File: rtl/tx_iq_sample_buffer.sv
// Elastic first-word-fall-through FIFO for signed I/Q pairs feeding the DAC link.
// Define IQ_PEAK_EN to add the peak_mag magnitude tracker cleared by clr_ovf.
module tx_iq_sample_buffer #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] real_in,
   input  logic [DATA_W-1:0] imag_in,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] real_out,
   output logic [DATA_W-1:0] imag_out,
   input  logic              out_ready,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
`ifdef IQ_PEAK_EN
   output logic [DATA_W-1:0] peak_mag,
`endif
   input  logic              clr_ovf
);

   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [DATA_W-1:0] mem_re [DEPTH];
   logic [DATA_W-1:0] mem_im [DEPTH];
   logic              full;
   logic              empty;
   logic              wr_en;
   logic              rd_en;

   // Extra pointer MSB separates full (laps differ) from empty (identical).
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign wr_en     = in_valid && !full;
   assign rd_en     = !empty && out_ready;

   assign real_out = mem_re[rd_ptr[ADDR_W-1:0]];
   assign imag_out = mem_im[rd_ptr[ADDR_W-1:0]];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_re[wr_ptr[ADDR_W-1:0]] <= real_in;
         mem_im[wr_ptr[ADDR_W-1:0]] <= imag_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (wr_en && !rd_en)
            level <= level + PTR_ONE;
         else if (rd_en && !wr_en)
            level <= level - PTR_ONE;
      end
   end

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         overflow <= 1'b0;
      else if (in_valid && full)
         overflow <= 1'b1;
      else if (clr_ovf)
         overflow <= 1'b0;
   end

`ifdef IQ_PEAK_EN
   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
      logic [DATA_W-1:0] neg;
      neg = -x;
      if (!x[DATA_W-1])
         mag = x;
      else if (x == MOST_NEG)
         mag = MOST_POS;
      else
         mag = neg;
   endfunction

   logic [DATA_W-1:0] mag_re;
   logic [DATA_W-1:0] mag_im;
   logic [DATA_W-1:0] mag_new;

   assign mag_re  = mag(real_in);
   assign mag_im  = mag(imag_in);
   assign mag_new = (mag_re > mag_im) ? mag_re : mag_im;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         peak_mag <= '0;
      else if (wr_en)
         peak_mag <= (clr_ovf || mag_new > peak_mag) ? mag_new : peak_mag;
      else if (clr_ovf)
         peak_mag <= '0;
   end
`endif

endmodule

// File: tb/tb_tx_iq_sample_buffer.sv
// Directed bench for tx_iq_sample_buffer with a queue-based reference model.
// Peak tracking is checked when IQ_PEAK_EN is defined.
module tb_tx_iq_sample_buffer;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] real_in = '0;
   logic [DATA_W-1:0] imag_in = '0;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] real_out;
   logic [DATA_W-1:0] imag_out;
   logic              out_ready = 1'b0;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              clr_ovf = 1'b0;
`ifdef IQ_PEAK_EN
   logic [DATA_W-1:0] peak_mag;
`endif

   tx_iq_sample_buffer #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .real_in  (real_in),
      .imag_in  (imag_in),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .real_out (real_out),
      .imag_out (imag_out),
      .out_ready(out_ready),
      .level    (level),
      .overflow (overflow),
`ifdef IQ_PEAK_EN
      .peak_mag (peak_mag),
`endif
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int mq_re[$];
   int mq_im[$];
   bit m_ovf = 1'b0;
   int m_peak = 0;

   task automatic chk(string n, logic signed [31:0] got, logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", n, got, exp);
      end
   endtask

   function automatic int absq(int v);
      int a;
      a = (v < 0) ? -v : v;
      return (a > 32767) ? 32767 : a;
   endfunction

   // Reference model: a queue of pairs plus sticky flag and peak.
   initial begin : model
      bit acc;
      bit rd;
      int m;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            mq_re.delete();
            mq_im.delete();
            m_ovf  = 1'b0;
            m_peak = 0;
         end else begin
            acc = in_valid && (mq_re.size() < DEPTH);
            rd  = out_ready && (mq_re.size() > 0);
            m   = absq(int'($signed(real_in)));
            if (absq(int'($signed(imag_in))) > m)
               m = absq(int'($signed(imag_in)));
            if (in_valid && !acc)
               m_ovf = 1'b1;
            else if (clr_ovf)
               m_ovf = 1'b0;
            if (acc)
               m_peak = (clr_ovf || m > m_peak) ? m : m_peak;
            else if (clr_ovf)
               m_peak = 0;
            if (rd) begin
               void'(mq_re.pop_front());
               void'(mq_im.pop_front());
            end
            if (acc) begin
               mq_re.push_back(int'($signed(real_in)));
               mq_im.push_back(int'($signed(imag_in)));
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         chk("level", level, mq_re.size());
         chk("out_valid", out_valid, mq_re.size() != 0);
         chk("in_ready", in_ready, mq_re.size() != DEPTH);
         chk("overflow", overflow, m_ovf);
         if (mq_re.size() != 0) begin
            chk("head_re", $signed(real_out), mq_re[0]);
            chk("head_im", $signed(imag_out), mq_im[0]);
         end
`ifdef IQ_PEAK_EN
         chk("peak_mag", peak_mag, m_peak);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(int re, int im);
      in_valid = 1'b1;
      real_in  = DATA_W'(re);
      imag_in  = DATA_W'(im);
      step();
      in_valid = 1'b0;
   endtask

   task automatic rst();
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
   endtask

   int rd[$];

   initial begin : stim
      #2 reset = 1'b0;
      step();
      step();
      chk("rst_level", level, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_overflow", overflow, 0);
      reset = 1'b1;
      step();

      push(100, -100);
      push(200, -200);
      push(300, -300);
      chk("t1_level", level, 3);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_head_re", $signed(real_out), 100);
      chk("t1_head_im", $signed(imag_out), -100);
      chk("t1_overflow", overflow, 0);

      rst();
      for (int i = 0; i < 16; i++)
         push(1000 + i, -1000 - i);
      chk("t2_in_ready", in_ready, 0);
      chk("t2_level", level, 16);
      push(7, 7);
      chk("t2_overflow", overflow, 1);
      chk("t2_level_hold", level, 16);

      in_valid  = 1'b1;
      real_in   = DATA_W'(7);
      imag_in   = DATA_W'(7);
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("t3_level", level, 15);
      chk("t3_in_ready", in_ready, 1);
      chk("t3_head_re", $signed(real_out), 1001);
      push(8, 8);
      chk("t3_refill", level, 16);

      rd.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rd.push_back(int'($signed(real_out)));
         step();
      end
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++)
         chk("t3_drain", rd[i], (i < 15) ? 1001 + i : 8);
      chk("t3_empty", level, 0);

      rd.delete();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         real_in = DATA_W'(k);
         imag_in = DATA_W'(-k);
         if (out_valid)
            rd.push_back(int'($signed(real_out)));
         step();
      end
      chk("t4_level", level, 1);
      in_valid = 1'b0;
      if (out_valid)
         rd.push_back(int'($signed(real_out)));
      step();
      out_ready = 1'b0;
      chk("t4_count", rd.size(), 40);
      for (int i = 0; i < rd.size(); i++)
         chk("t4_order", rd[i], i);
      chk("t4_sticky_ovf", overflow, 1);

      for (int i = 0; i < 5; i++)
         push(500 + i, i);
      chk("t5_level", level, 5);
      reset = 1'b0;
      #1;
      chk("t5_async_level", level, 0);
      chk("t5_async_valid", out_valid, 0);
      chk("t5_async_ready", in_ready, 1);
      chk("t5_async_ovf", overflow, 0);
      step();
      reset = 1'b1;
      step();
      push(55, -55);
      chk("t5_first_re", $signed(real_out), 55);
      chk("t5_first_im", $signed(imag_out), -55);
      chk("t5_level_after", level, 1);

      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++)
         push(i, -i);
      in_valid = 1'b1;
      real_in  = DATA_W'(9);
      clr_ovf  = 1'b1;
      step();
      in_valid = 1'b0;
      clr_ovf  = 1'b0;
      chk("ovf_set_wins", overflow, 1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("ovf_cleared", overflow, 0);

`ifdef IQ_PEAK_EN
      rst();
      push(-32768, 5);
      push(1000, -2000);
      chk("t6_peak", peak_mag, 32767);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("t6_peak_clr", peak_mag, 0);
      chk("t6_ovf_clr", overflow, 0);
      clr_ovf = 1'b1;
      push(-300, 12);
      clr_ovf = 1'b0;
      chk("t6_clr_write", peak_mag, 300);
`endif

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
